uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter that queues bytes in an internal FIFO and frames them on tx.
//  Frame format is build-time configurable: data bits, parity, stop bits. Baud divisor is a runtime input.
//  Sits between the host/measurement logic and the board UART pin.
//  Generalises the fixed 8N1 single-byte transmitter: valid/ready input, back-to-back frames, parity and 2-stop support.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9, sent LSB first
//  PARITY      0   0 = none, 1 = odd, 2 = even
//  STOP_BITS   1   stop bits per frame, 1 or 2
//  FIFO_DEPTH  4   FIFO entries, power of two, >= 2
//  DIV_W       16  width of baud_div
// PORTS
//  clk        in   1                    system clock
//  rst_n      in   1                    asynchronous active-low reset
//  baud_div   in   DIV_W                clock cycles per bit; values 0 and 1 are treated as 2
//  tx_en      in   1                    0 = do not start new frames; a frame in progress completes
//  in_data    in   DATA_BITS            byte to queue
//  in_valid   in   1                    in_data is valid
//  in_ready   out  1                    FIFO not full; a push occurs on in_valid & in_ready
//  tx         out  1                    serial line, idle high
//  busy       out  1                    a frame is on the line
//  done       out  1                    1-cycle pulse in the last cycle of each frame's final stop bit
//  fifo_level out  $clog2(FIFO_DEPTH)+1 number of queued entries
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Outputs: tx=1, busy=0, done=0, fifo_level=0, in_ready=1.
//   - FIFO pointers are cleared. FSM goes to IDLE.
//   - Reset mid-frame aborts the frame and drives tx high immediately.
//  FIFO:
//   - in_ready = (fifo_level != FIFO_DEPTH).
//   - A pop and a push in the same cycle are both honoured; the level is unchanged.
//   - A push while full is impossible, since in_ready=0.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Divisor:
//   - baud_div is sampled when a frame starts and held for the whole frame.
//   - Mid-frame changes to baud_div affect only the next frame.
//   - Bit counter runs 0..div-1; each bit lasts exactly div cycles.
//  FSM states: IDLE, START, DATA, PAR, STOP.
//   - IDLE: if tx_en & fifo_level != 0, pop the head into the shift register -> START.
//     The start bit (tx=0) is on the line in the next cycle.
//   - START: 1 bit period at tx=0 -> DATA.
//   - DATA: DATA_BITS bit periods, LSB first -> PAR if PARITY != 0, else STOP.
//   - PAR: 1 bit period.
//     Odd: tx = ~^data. Even: tx = ^data.
//   - STOP: STOP_BITS bit periods at tx=1. done pulses in the last cycle.
//     Next: if tx_en & FIFO not empty, pop and go straight to START. The next start bit follows with no idle gap.
//     Otherwise go to IDLE.
//  Outputs and timing:
//   - busy=1 in every state except IDLE.
//   - tx is registered.
//   - Frame length = div*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
//   - Latency from push into an empty idle FIFO to the tx falling edge: 2 cycles.
//  tx_en deassertion:
//   - Takes effect only at frame boundaries.
//   - Queued data is retained and sent when tx_en returns to 1.
// TESTING
//  - DATA_BITS=8, PARITY=0, STOP=1, div=4; push 0xA5.
//    -> tx = 0,1,0,1,0,0,1,0,1,1, 4 cycles each. 40-cycle frame. One done pulse.
//  - PARITY=2 (even), push 0x07 -> parity bit 1.
//    PARITY=1 (odd), push 0x07 -> parity bit 0.
//    STOP_BITS=2 -> tx high for 8 cycles after the parity bit.
//  - Push 5 bytes 0x11..0x15 with tx_en=0, FIFO_DEPTH=4.
//    -> in_ready drops after the 4th push; fifo_level=4.
//    -> Raise tx_en: 4 frames back-to-back with no idle cycle, 4 done pulses.
//  - Change baud_div 4->8 mid-frame.
//    -> Current frame keeps 4 cycles/bit. The next frame uses 8.
//    -> baud_div=0 gives 2 cycles/bit.
//  - Assert rst_n=0 during DATA bits with 2 entries queued.
//    -> tx=1 and fifo_level=0 immediately, no done pulse.
//    -> After release, line idle until a new push.
//  - Push and pop in the same cycle at level 1.
//    -> Level stays 1. Byte order is preserved in the tx stream (scoreboard against the push order).

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Frame format is fixed at build time; the bit period comes from baud_div at runtime.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          tx_en,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS-1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS-1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [2:0]           state;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_eff;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 par_q;
  logic                 par_in;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_end;

  assign head     = mem[rd_ptr];
  assign par_in   = (PARITY == 1) ? ~^head : ^head;
  assign in_ready = fifo_level != FULL;
  assign push     = in_valid & in_ready;
  assign bit_end  = cnt == div_q - DIV_W'(1);
  assign stop_end = (state == STOP) && bit_end && (idx == LAST_STOP);
  assign pop      = tx_en && (fifo_level != '0)
                 && ((state == IDLE) || stop_end);
  assign div_eff  = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign busy     = state != IDLE;
  assign done     = stop_end;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // tx is loaded with the value of the bit that starts at this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= 1'b1;
      cnt   <= '0;
      idx   <= '0;
      div_q <= DIV_W'(2);
      shreg <= '0;
      par_q <= 1'b0;
    end else if (pop) begin
      state <= START;
      tx    <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      div_q <= div_eff;
      shreg <= head;
      par_q <= par_in;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt <= cnt + DIV_W'(1);
      end else begin
        cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            tx    <= shreg[0];
          end
          DATA: begin
            if (idx == LAST_DATA) begin
              idx <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_q;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              idx   <= idx + 4'd1;
              shreg <= shreg >> 1;
              tx    <= shreg[1];
            end
          end
          PAR: begin
            state <= STOP;
            tx    <= 1'b1;
          end
          STOP: begin
            if (idx == LAST_STOP) state <= IDLE;
            else idx <= idx + 4'd1;
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats driven in parallel,
// each line decoded frame by frame against the queue of pushed bytes.
module tb_uart_tx_fifo;

  localparam int DB [3] = '{8, 8, 7};
  localparam int PR [3] = '{0, 2, 1};
  localparam int SB [3] = '{1, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        tx_en;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [2:0]  rdy_o;
  logic [2:0]  tx_o;
  logic [2:0]  busy_o;
  logic [2:0]  done_o;
  logic [2:0]  lvl_o [3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  pushed [$];
  int          rd   [3];
  bit          act  [3];
  int          cyc  [3];
  int          len  [3];
  int          divm [3];
  int          bad  [3];
  logic [15:0] fbits [3];
  logic [15:0] prev_div;
  logic        prev_en;

  always #5 clk = ~clk;

  uart_tx_fifo u0 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_en(tx_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_o[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .fifo_level(lvl_o[0])
  );

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_en(tx_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_o[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .fifo_level(lvl_o[1])
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_en(tx_en),
    .in_data(in_data[6:0]), .in_valid(in_valid), .in_ready(rdy_o[2]),
    .tx(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .fifo_level(lvl_o[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(int d, logic [7:0] b);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < DB[d]; i++) begin
      f[1+i] = b[i];
      ones += int'(b[i]);
    end
    if (PR[d] == 1) f[1+DB[d]] = (ones % 2 == 0);
    if (PR[d] == 2) f[1+DB[d]] = (ones % 2 == 1);
    return f;
  endfunction

  // line decoder: a falling tx outside a frame starts the next queued byte
  always @(negedge clk) begin
    logic [7:0] b;
    if (!rst_n) begin
      pushed.delete();
      for (int d = 0; d < 3; d++) begin
        act[d] = 0;
        rd[d]  = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (!act[d]) begin
          if (tx_o[d] === 1'b0) begin
            chk($sformatf("start%0d", d),
                {30'd0, rd[d] < pushed.size(), prev_en}, 32'd3);
            b = (rd[d] < pushed.size()) ? pushed[rd[d]] : 8'h00;
            rd[d]++;
            fbits[d] = frame_bits(d, b);
            divm[d]  = (prev_div < 16'd2) ? 2 : int'(prev_div);
            len[d]   = divm[d] * (1 + DB[d] + (PR[d] != 0 ? 1 : 0) + SB[d]);
            cyc[d]   = 0;
            bad[d]   = 0;
            act[d]   = 1;
          end else begin
            chk($sformatf("idle%0d", d),
                {30'd0, busy_o[d], done_o[d]}, 32'd0);
          end
        end
        if (act[d]) begin
          if (tx_o[d] !== fbits[d][cyc[d] / divm[d]] || busy_o[d] !== 1'b1
              || done_o[d] !== (cyc[d] == len[d] - 1))
            bad[d]++;
          cyc[d]++;
          if (cyc[d] == len[d]) begin
            act[d] = 0;
            chk($sformatf("frame%0d_bad_cycles", d), bad[d], 0);
          end
        end
      end
    end
    prev_div = baud_div;
    prev_en  = tx_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (rdy_o !== 3'b111 && n < 5000) begin
      tx_en = 1'b1;
      tick();
      n++;
    end
    chk("push_wait", {31'd0, n < 5000}, 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    pushed.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o !== 3'b000 || rd[0] != pushed.size()
            || rd[1] != pushed.size() || rd[2] != pushed.size())
           && n < 20000) begin
      tick();
      n++;
    end
    chk("drain", {31'd0, n < 20000}, 32'd1);
  endtask

  task automatic count_busy(output int nb, output int nd);
    int n = 0;
    nb = 0;
    nd = 0;
    @(negedge clk);
    while (busy_o[0] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    while (busy_o[0] === 1'b1 && n < 5000) begin
      nb++;
      nd += int'(done_o[0]);
      @(negedge clk);
      n++;
    end
    chk("busy_bound", {31'd0, n < 5000}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic w [3][48];
    logic [9:0] v;
    logic [7:0] s;
    int nb, nd, di0, di1;

    rst_n    = 1'b0;
    baud_div = 16'd4;
    tx_en    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    repeat (3) tick();
    chk("rst_tx", tx_o, 3'b111);
    chk("rst_busy", busy_o, 3'b000);
    chk("rst_done", done_o, 3'b000);
    chk("rst_ready", rdy_o, 3'b111);
    chk("rst_level", {lvl_o[0], lvl_o[1], lvl_o[2]}, 0);
    rst_n = 1'b1;
    tx_en = 1'b1;
    repeat (3) tick();

    // 0xA5 at div 4, latency and exact waveform
    in_data  = 8'hA5;
    in_valid = 1'b1;
    pushed.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    chk("lat_level", lvl_o[0], 1);
    chk("lat_still_high", tx_o, 3'b111);
    tick();
    chk("lat_start", tx_o, 3'b000);
    di0 = -1;
    nb = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) w[d][i] = tx_o[d];
      nb += int'(busy_o[0]);
      if (done_o[0]) di0 = i;
    end
    for (int k = 0; k < 10; k++) v[k] = w[0][4*k+2];
    chk("a5_bits", v, 10'b1101001010);
    chk("a5_done_at", di0, 39);
    chk("a5_len", nb, 40);
    wait_idle();

    // 0x07 parity: even on u1, odd on u2 (7 data bits)
    in_data  = 8'h07;
    in_valid = 1'b1;
    pushed.push_back(8'h07);
    tick();
    in_valid = 1'b0;
    tick();
    di1 = -1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) w[d][i] = tx_o[d];
      if (done_o[1]) di1 = i;
    end
    chk("even_par", w[1][38], 1'b1);
    chk("odd_par", w[2][34], 1'b0);
    for (int k = 0; k < 8; k++) s[k] = w[1][40+k];
    chk("two_stop", s, 8'hFF);
    chk("u1_done_at", di1, 47);
    wait_idle();

    // fill with tx_en low, one push too many
    tx_en = 1'b0;
    for (int k = 0; k < 4; k++) push(8'h11 + 8'(k));
    chk("full_level", lvl_o[0], 4);
    chk("full_ready", rdy_o, 3'b000);
    in_data  = 8'h15;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full_hold", lvl_o[0], 4);
    tx_en = 1'b1;
    count_busy(nb, nd);
    chk("b2b_len", nb, 160);
    chk("b2b_done", nd, 4);
    wait_idle();

    // baud_div change mid-frame
    tx_en = 1'b0;
    push(8'h3C);
    push(8'hC3);
    tx_en = 1'b1;
    fork
      count_busy(nb, nd);
      begin
        repeat (10) tick();
        baud_div = 16'd8;
      end
    join
    chk("divchg_len", nb, 120);
    chk("divchg_done", nd, 2);
    wait_idle();
    baud_div = 16'd0;
    tx_en = 1'b0;
    push(8'h5A);
    tx_en = 1'b1;
    count_busy(nb, nd);
    chk("div0_len", nb, 20);
    chk("div0_done", nd, 1);
    wait_idle();

    // push and pop in the same cycle at level 1
    baud_div = 16'd2;
    push(8'h81);
    push(8'h42);
    chk("pp_level_before", lvl_o[0], 1);
    nb = 0;
    @(negedge clk);
    while (done_o[0] !== 1'b1 && nb < 200) begin
      @(negedge clk);
      nb++;
    end
    chk("pp_done_seen", {31'd0, nb < 200}, 32'd1);
    in_data  = 8'h99;
    in_valid = 1'b1;
    pushed.push_back(8'h99);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pp_level", lvl_o[0], 1);
    chk("pp_no_gap", tx_o[0], 1'b0);
    wait_idle();

    // reset while in DATA with two entries queued
    baud_div = 16'd4;
    push(8'hF0);
    push(8'h0F);
    push(8'hAA);
    chk("rst_q_level", lvl_o[0], 2);
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_o, 3'b111);
    chk("abort_level", lvl_o[0], 0);
    chk("abort_busy", busy_o, 3'b000);
    chk("abort_done", done_o, 3'b000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("post_rst_tx", tx_o, 3'b111);
    chk("post_rst_level", lvl_o[0], 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) baud_div = 16'($urandom_range(5));
      tx_en = ($urandom_range(7) != 0);
      push(8'($urandom));
      repeat ($urandom_range(15)) tick();
    end
    tx_en = 1'b1;
    wait_idle();
    chk("final_level", lvl_o[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
